// File: rtl/herald_pkg.sv
// Shared command codes, error codes, state encoding and command-table entry type
// for the Herald host front end.
package herald_pkg;

  localparam int unsigned CMD_OPS_W = 4;
  localparam int unsigned CMD_RES_W = 8;

  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_SINCOS    = 8'h10;
  localparam logic [7:0] CMD_ATAN2     = 8'h11;
  localparam logic [7:0] CMD_SQRT      = 8'h12;
  localparam logic [7:0] CMD_NORMALIZE = 8'h13;
  localparam logic [7:0] CMD_MUL       = 8'h20;
  localparam logic [7:0] CMD_MAC       = 8'h21;
  localparam logic [7:0] CMD_CLEAR     = 8'h22;
  localparam logic [7:0] CMD_MSU       = 8'h23;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_UNKNOWN = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_OPS,
    S_START,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [CMD_OPS_W-1:0] n_ops;
    logic [CMD_RES_W-1:0] n_res;
  } cmd_info_t;

  function automatic cmd_info_t cmd_entry(input int unsigned ops, input int unsigned res);
    return '{valid: 1'b1, n_ops: CMD_OPS_W'(ops), n_res: CMD_RES_W'(res)};
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/herald_cmd_decode.sv
// Combinational command table: command code -> {valid, operand count, result bytes}.
module herald_cmd_decode
  import herald_pkg::*;
(
  input  logic [7:0] cmd,
  output cmd_info_t  info
);

  always_comb begin
    info = '{valid: 1'b0, n_ops: '0, n_res: '0};
    case (cmd)
      CMD_STATUS:    info = cmd_entry(0, 1);
      CMD_SINCOS:    info = cmd_entry(1, 6);
      CMD_ATAN2:     info = cmd_entry(2, 3);
      CMD_SQRT:      info = cmd_entry(2, 3);
      CMD_NORMALIZE: info = cmd_entry(2, 9);
      CMD_MUL:       info = cmd_entry(2, 3);
      CMD_MAC:       info = cmd_entry(2, 3);
      CMD_CLEAR:     info = cmd_entry(0, 0);
      CMD_MSU:       info = cmd_entry(2, 3);
      default:       info = '{valid: 1'b0, n_ops: '0, n_res: '0};
    endcase
  end

endmodule

// File: rtl/herald_host_if.sv
// Byte-serial host front end: collects a command and its operands, runs the
// compute engine through a start/done handshake and streams the result back.
module herald_host_if
  import herald_pkg::*;
#(
  parameter int unsigned OPW_BYTES      = 3,
  parameter int unsigned MAX_OPS        = 2,
  parameter int unsigned MAX_RES_BYTES  = 9,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_strobe,
  input  logic                             rd_strobe,
  input  logic                             abort,
  input  logic [7:0]                       din,
  output logic [7:0]                       dout,
  output logic                             busy,
  output logic                             err,
  output logic                             eng_start,
  output logic [7:0]                       eng_cmd,
  output logic [MAX_OPS*OPW_BYTES*8-1:0]   eng_ops,
  output logic                             eng_abort,
  input  logic                             eng_done,
  input  logic [MAX_RES_BYTES*8-1:0]       eng_result
);

  localparam int unsigned OPS_BYTES = MAX_OPS * OPW_BYTES;
  localparam int unsigned OPS_W     = OPS_BYTES * 8;
  localparam int unsigned RES_W     = MAX_RES_BYTES * 8;
  localparam int unsigned IDX_W     = $clog2(max_u(OPS_BYTES, MAX_RES_BYTES) + 1);
  localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [IDX_W-1:0]   n_op_bytes, n_op_bytes_d;
  logic [IDX_W-1:0]   n_res, n_res_d;
  logic [WD_W-1:0]    wdog, wdog_d;
  logic [7:0]         dout_d, eng_cmd_d;
  logic               busy_d, err_d, eng_start_d, eng_abort_d;
  logic [2:0]         err_code, err_code_d;
  logic [OPS_W-1:0]   eng_ops_d;
  logic [RES_W-1:0]   result, result_d;
  logic               wr_q, rd_q;
  logic               wr_edge, rd_edge, abort_hit, accept, cmd_ok;
  cmd_info_t          info;

  herald_cmd_decode u_decode (
    .cmd  (din),
    .info (info)
  );

  assign wr_edge   = wr_strobe & ~wr_q;
  assign rd_edge   = rd_strobe & ~rd_q;
  assign abort_hit = abort & (state != S_IDLE);
  assign accept    = wr_edge & ~abort_hit &
                     ((state == S_IDLE) | (state == S_RESULT) | (state == S_ERROR));
  // Entries that do not fit this instance's widths are rejected like unknown codes.
  assign cmd_ok    = info.valid && (32'(info.n_ops) <= MAX_OPS) &&
                     (32'(info.n_res) <= MAX_RES_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      n_op_bytes <= '0;
      n_res      <= '0;
      wdog       <= '0;
      dout       <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      eng_cmd    <= '0;
      eng_ops    <= '0;
      result     <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      n_op_bytes <= n_op_bytes_d;
      n_res      <= n_res_d;
      wdog       <= wdog_d;
      dout       <= dout_d;
      busy       <= busy_d;
      err        <= err_d;
      err_code   <= err_code_d;
      eng_start  <= eng_start_d;
      eng_abort  <= eng_abort_d;
      eng_cmd    <= eng_cmd_d;
      eng_ops    <= eng_ops_d;
      result     <= result_d;
      wr_q       <= wr_strobe;
      rd_q       <= rd_strobe;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    n_op_bytes_d = n_op_bytes;
    n_res_d      = n_res;
    wdog_d       = wdog;
    dout_d       = dout;
    busy_d       = busy;
    err_d        = err;
    err_code_d   = err_code;
    eng_abort_d  = 1'b0;
    eng_start_d  = 1'b0;
    eng_cmd_d    = eng_cmd;
    eng_ops_d    = eng_ops;
    result_d     = result;

    case (state)
      S_IDLE: ;
      S_GET_OPS: begin
        if (wr_edge) begin
          for (int i = 0; i < OPS_BYTES; i++) begin
            if (idx == IDX_W'(i)) eng_ops_d[8*i +: 8] = din;
          end
          idx_d = idx + IDX_W'(1);
          if (idx == n_op_bytes - IDX_W'(1)) state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = wdog + WD_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog + WD_W'(1);
        if (eng_done) begin
          result_d = eng_result;
          idx_d    = '0;
          busy_d   = 1'b0;
          state_d  = (n_res == '0) ? S_IDLE : S_RESULT;
        end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          eng_abort_d = 1'b1;
          err_d       = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          busy_d      = 1'b0;
          state_d     = S_ERROR;
        end else if (wr_edge) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end
      S_RESULT: begin
        if (rd_edge) begin
          for (int i = 0; i < MAX_RES_BYTES; i++) begin
            if (idx == IDX_W'(i)) dout_d = result[8*i +: 8];
          end
          idx_d = idx + IDX_W'(1);
          if (idx == n_res - IDX_W'(1)) state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (rd_edge) begin
          dout_d  = {5'b0, err_code};
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks strobes; a new command byte can interrupt RESULT/ERROR.
    if (abort_hit) begin
      eng_abort_d = (state == S_WAIT);
      err_d       = 1'b1;
      err_code_d  = ERR_ABORT;
      busy_d      = 1'b0;
      state_d     = S_ERROR;
    end else if (accept) begin
      eng_cmd_d    = din;
      err_d        = 1'b0;
      err_code_d   = ERR_NONE;
      busy_d       = 1'b1;
      idx_d        = '0;
      n_op_bytes_d = IDX_W'(32'(info.n_ops) * OPW_BYTES);
      n_res_d      = IDX_W'(info.n_res);
      if (!cmd_ok) begin
        err_d      = 1'b1;
        err_code_d = ERR_UNKNOWN;
        busy_d     = 1'b0;
        state_d    = S_ERROR;
      end else if (din == CMD_STATUS) begin
        result_d[7:0] = {busy, 4'b0, ERR_NONE};
        busy_d        = 1'b0;
        state_d       = S_RESULT;
      end else if (info.n_ops == '0) begin
        state_d = S_START;
      end else begin
        state_d = S_GET_OPS;
      end
    end

    // Watchdog counts from the start-pulse cycle.
    if (state_d == S_START) begin
      eng_start_d = 1'b1;
      wdog_d      = '0;
    end
  end

endmodule

// File: doc/herald_host_if.md
Name: herald_host_if

Overview:
Parameterised byte-serial host front end for the Herald accelerator. Replaces the fixed 24-bit, fixed-command host FSM with a generic one:
- operand width, operand count and result length come from parameters and a shared command table;
- it drives any compute engine through one start/done handshake.

It adds features the previous generation lacks: error reporting, a watchdog timeout, a host abort, a STATUS command, and back-to-back command pipelining from the result phase.

Parameters:
- OPW_BYTES, 3: bytes per operand (operand width = 8*OPW_BYTES).
- MAX_OPS, 2: maximum operands per command.
- MAX_RES_BYTES, 9: maximum result bytes per command.
- TIMEOUT_CYCLES, 4096: engine watchdog limit in clk cycles; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wr_strobe  in  1  host write strobe; action on rising edge
- rd_strobe  in  1  host read strobe; action on rising edge
- abort  in  1  host abort, level-sampled
- din  in  8  host write data
- dout  out  8  registered host read data
- busy  out  1  high from command accept until result ready, error or idle
- err  out  1  sticky error flag
- eng_start  out  1  one-cycle start pulse
- eng_cmd  out  8  latched command code
- eng_ops  out  MAX_OPS*OPW_BYTES*8  operands; op0 at LSBs; each operand LSB byte first
- eng_abort  out  1  one-cycle pulse on timeout or host abort while the engine is running
- eng_done  in  1  engine completion pulse
- eng_result  in  MAX_RES_BYTES*8  result, sampled on eng_done

Behaviour:
- Reset: the following are held while rst=1 and for the first cycle after.
  - state=IDLE
  - dout=0, busy=0, err=0, err_code=0
  - eng_start=0, eng_abort=0, eng_cmd=0, eng_ops=0
  - strobe-history registers=0
- Edge detection: edge = strobe & ~strobe_q. This gives 1-cycle detect latency. Strobes are synchronous to clk.
- Command table: herald_cmd_decode maps cmd to {valid, n_ops, n_res}.
  - 0x00 STATUS: 0 operands, 1 result byte, handled internally, no engine start.
- States:
  - IDLE: busy=0. A wr edge latches din into eng_cmd, clears err/err_code and sets busy=1.
    - Unknown cmd → ERROR with code 1.
    - n_ops=0 → START (STATUS goes straight to RESULT with byte {busy_q, 4'b0, err_code}).
    - Otherwise → GET_OPS.
  - GET_OPS: each wr edge stores din at byte index idx. idx counts 0..n_ops*OPW_BYTES-1. At the last byte → START.
  - START: eng_start=1 for exactly one cycle; → WAIT; watchdog cleared.
  - WAIT: the watchdog increments each cycle.
    - eng_done → capture eng_result; idx=0; → RESULT. busy drops the next cycle.
    - Watchdog reaches TIMEOUT_CYCLES without done → eng_abort pulse; ERROR with code 2.
    - eng_done in the expiry cycle: done wins.
    - A wr edge → ignored, err_code=3 (overrun), err=1. Remain in WAIT.
  - RESULT: each rd edge drives dout = result byte idx, LSB first; idx++. After byte n_res-1 → IDLE.
    - A wr edge here abandons the remaining bytes and is treated as an IDLE command byte in the same cycle.
  - ERROR: busy=0, err=1. A rd edge drives dout={5'b0, err_code}; → IDLE, err stays set. A wr edge is treated as an IDLE command.
- Error codes: 1 unknown command, 2 timeout, 3 overrun, 4 abort.
- Abort: abort=1 in any state except IDLE → ERROR with code 4. In WAIT it also pulses eng_abort. abort has priority over wr/rd edges in the same cycle. In IDLE it is ignored.
- rd edge outside RESULT/ERROR: ignored, dout holds.
- eng_done outside WAIT: ignored.
- eng_ops/eng_cmd: stable from START through leaving WAIT. They may be overwritten only by GET_OPS of the next command.
- Reset mid-operation: immediate return to reset values. No eng_abort pulse is issued.
- Widths: idx is clog2(max(MAX_OPS*OPW_BYTES, MAX_RES_BYTES)+1) bits. The watchdog is clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- herald_pkg holds:
  - command-code localparams (STATUS 0x00, SINCOS 0x10, ATAN2 0x11, SQRT 0x12, NORMALIZE 0x13, MUL 0x20, MAC 0x21, CLEAR 0x22, MSU 0x23);
  - error-code constants;
  - the state encoding.
- Sub-module herald_cmd_decode (combinational table lookup) keeps per-command lengths out of the FSM. Table lengths:
  - SINCOS: 1 op, 6 result bytes.
  - ATAN2 and SQRT: 2 ops, 3 result bytes.
  - NORMALIZE: 2 ops, 9 result bytes.
  - MUL and MAC: 2 ops, 3 result bytes.
  - CLEAR: 0 ops, 0 result bytes (→ IDLE directly on done).
  - MSU: 2 ops, 3 result bytes.

Test Plan:
- MUL: write 0x20, then 01 00 00, then 02 00 00. Engine done after 5 cycles with result 0x000200. Expect one eng_start, eng_ops=0x000002_000001, and reads returning 00, 02, 00. busy low after the third read.
- NORMALIZE with 9-byte result 0x090807060504030201: reads return 01..09 in order; state IDLE afterwards.
- Unknown cmd 0x55 → err=1, busy=0. Read returns 0x01. Next write of 0x00 (STATUS) clears err; read returns 0x00.
- SQRT with no eng_done, TIMEOUT_CYCLES=16 → eng_abort pulse exactly 16 cycles after START; err=1; read returns 0x02.
- abort asserted mid-GET_OPS after 2 bytes → ERROR, code 4, no eng_start. abort with a simultaneous wr edge → abort wins.
- SINCOS result readout: after 2 of 6 bytes, write 0x22 → CLEAR starts immediately (eng_start pulse); remaining bytes discarded. A wr edge during WAIT gives err_code 3 and completion still succeeds.
